// File: rtl/lc3_mem_access_ctrl.sv
// rtl/lc3_mem_access_ctrl.sv - LC-3 data-memory access sequencer with wait-state watchdog
module lc3_mem_access_ctrl #(
  parameter int P_TIMEOUT = 16,
  parameter int P_CNT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_marmux_sel,
  output logic       o_ld_mar,
  output logic       o_mar_from_mdr,
  output logic       o_ld_mdr,
  output logic       o_mdr_sel,
  output logic       o_mem_en,
  output logic       o_mem_we,
  output logic       o_ld_reg,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // Last count value tolerated before the watchdog fires; unused when P_TIMEOUT is 0.
  localparam logic [P_CNT_W-1:0] WAIT_LIMIT = P_CNT_W'((P_TIMEOUT > 0) ? (P_TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WRDATA,
    S_READ,
    S_IND,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [3:0]         opcode;
  logic               ind;
  logic [P_CNT_W-1:0] wait_cnt;

  logic is_legal;
  logic is_trap;
  logic is_direct_store;
  logic is_indirect;
  logic is_load;
  logic timeout;

  // Opcode class decode: legality is judged on the live input, the rest on the latched opcode.
  always_comb begin
    is_legal = 1'b0;
    case (i_opcode)
      OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR, OP_TRAP: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
    is_trap         = (opcode == OP_TRAP);
    is_direct_store = (opcode == OP_ST) || (opcode == OP_STR);
    is_indirect     = (opcode == OP_LDI) || (opcode == OP_STI);
    is_load         = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_LDR);
    timeout         = (P_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);
  end

  // Sequencer state, opcode latch, indirect-pass flag and watchdog counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      opcode   <= 4'b0000;
      ind      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (is_legal) begin
              opcode <= i_opcode;
              ind    <= 1'b0;
              state  <= S_ADDR;
            end else begin
              state  <= S_ERR;
            end
          end
        end
        S_ADDR: begin
          if (is_direct_store) begin
            state <= S_WRDATA;
          end else begin
            state    <= S_READ;
            wait_cnt <= '0;
          end
        end
        S_READ: begin
          if (i_mem_ready) begin
            // First read of LDI/STI fetched the pointer; go load it into MAR.
            state <= (is_indirect && !ind) ? S_IND : S_DONE;
          end else if (timeout) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_IND: begin
          ind <= 1'b1;
          if (opcode == OP_LDI) begin
            state    <= S_READ;
            wait_cnt <= '0;
          end else begin
            state <= S_WRDATA;
          end
        end
        S_WRDATA: begin
          state    <= S_WRITE;
          wait_cnt <= '0;
        end
        S_WRITE: begin
          if (i_mem_ready) begin
            state <= S_DONE;
          end else if (timeout) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath and memory controls decoded from the state register; MDR load in READ follows ready.
  always_comb begin
    o_marmux_sel   = 1'b0;
    o_ld_mar       = 1'b0;
    o_mar_from_mdr = 1'b0;
    o_ld_mdr       = 1'b0;
    o_mdr_sel      = 1'b0;
    o_mem_en       = 1'b0;
    o_mem_we       = 1'b0;
    o_ld_reg       = 1'b0;
    o_done         = 1'b0;
    o_err          = 1'b0;
    o_busy         = (state != S_IDLE);
    case (state)
      S_ADDR: begin
        o_ld_mar     = 1'b1;
        o_marmux_sel = !is_trap;
      end
      S_READ: begin
        o_mem_en  = 1'b1;
        o_mdr_sel = 1'b0;
        o_ld_mdr  = i_mem_ready;
      end
      S_IND: begin
        o_mar_from_mdr = 1'b1;
        o_ld_mar       = 1'b1;
      end
      S_WRDATA: begin
        o_ld_mdr  = 1'b1;
        o_mdr_sel = 1'b1;
      end
      S_WRITE: begin
        o_mem_en = 1'b1;
        o_mem_we = 1'b1;
      end
      S_DONE: begin
        o_done   = 1'b1;
        o_ld_reg = is_load;
      end
      S_ERR: begin
        o_err = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// tb/tb_lc3_mem_access_ctrl.sv - scoreboard bench for lc3_mem_access_ctrl
module tb_lc3_mem_access_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [3:0] i_opcode = 4'b0000;
  logic       i_mem_ready = 1'b0;
  logic       o_marmux_sel, o_ld_mar, o_mar_from_mdr, o_ld_mdr, o_mdr_sel;
  logic       o_mem_en, o_mem_we, o_ld_reg, o_busy, o_done, o_err;

  lc3_mem_access_ctrl #(.P_TIMEOUT(4), .P_CNT_W(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_opcode       (i_opcode),
    .i_mem_ready    (i_mem_ready),
    .o_marmux_sel   (o_marmux_sel),
    .o_ld_mar       (o_ld_mar),
    .o_mar_from_mdr (o_mar_from_mdr),
    .o_ld_mdr       (o_ld_mdr),
    .o_mdr_sel      (o_mdr_sel),
    .o_mem_en       (o_mem_en),
    .o_mem_we       (o_mem_we),
    .o_ld_reg       (o_ld_reg),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Output word: marmux_sel ld_mar mar_from_mdr ld_mdr mdr_sel mem_en mem_we ld_reg busy done err
  localparam logic [10:0] W_ADDR_OFS  = 11'b1_1_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] W_ADDR_TRAP = 11'b0_1_0_0_0_0_0_0_1_0_0;
  localparam logic [10:0] W_READ      = 11'b0_0_0_0_0_1_0_0_1_0_0;
  localparam logic [10:0] W_READ_RDY  = 11'b0_0_0_1_0_1_0_0_1_0_0;
  localparam logic [10:0] W_IND       = 11'b0_1_1_0_0_0_0_0_1_0_0;
  localparam logic [10:0] W_WRDATA    = 11'b0_0_0_1_1_0_0_0_1_0_0;
  localparam logic [10:0] W_WRITE     = 11'b0_0_0_0_0_1_1_0_1_0_0;
  localparam logic [10:0] W_DONE      = 11'b0_0_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] W_DONE_REG  = 11'b0_0_0_0_0_0_0_1_1_1_0;
  localparam logic [10:0] W_ERR       = 11'b0_0_0_0_0_0_0_0_1_0_1;
  localparam logic [10:0] W_IDLE      = 11'b0;

  logic [10:0] exp_q[$];
  logic [11:0] steps[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  function automatic void add(input logic rdy, input logic [10:0] w);
    steps.push_back({rdy, w});
  endfunction

  function automatic void add_read(input int waits);
    for (int i = 0; i < waits; i++) add(1'b0, W_READ);
    add(1'b1, W_READ_RDY);
  endfunction

  function automatic void add_write(input int waits);
    for (int i = 0; i < waits; i++) add(1'b0, W_WRITE);
    add(1'b1, W_WRITE);
  endfunction

  // Drives one transaction from an IDLE cycle; expected words are queued as each cycle is driven.
  task automatic run(input logic [3:0] op, input bit noisy, input bit rst_tail);
    i_start = 1'b1;
    i_opcode = op;
    i_mem_ready = 1'b0;
    foreach (steps[k]) begin
      @(posedge i_clk); #1;
      if (noisy) begin
        i_start = 1'b1;
        i_opcode = 4'b0001;
      end else begin
        i_start = 1'b0;
      end
      i_mem_ready = steps[k][11];
      exp_q.push_back(steps[k][10:0]);
    end
    steps.delete();
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_mem_ready = 1'b0;
    if (rst_tail) begin
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
    end
  endtask

  // Monitor: every busy cycle pops the next expected word, every idle cycle must show all-zero outputs.
  always @(negedge i_clk) begin
    logic [10:0] act;
    logic [10:0] exp_w;
    string name;
    act = {o_marmux_sel, o_ld_mar, o_mar_from_mdr, o_ld_mdr, o_mdr_sel,
           o_mem_en, o_mem_we, o_ld_reg, o_busy, o_done, o_err};
    if (act[2]) begin
      name = "trace";
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL trace_extra: got %b required idle (no expected cycle queued)", act);
      end else begin
        exp_w = exp_q.pop_front();
        chk_cnt++;
        if (act === exp_w) pass_cnt++;
        else $display("FAIL %s: got %b required %b at %0t", name, act, exp_w, $time);
      end
    end else begin
      name = i_rst ? "reset" : "idle";
      chk_cnt++;
      if (act === W_IDLE && exp_q.size() == 0) pass_cnt++;
      else $display("FAIL %s: got %b required %b (pending %0d) at %0t",
                    name, act, W_IDLE, exp_q.size(), $time);
    end
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // LD, ready on first READ; start held high with an illegal opcode throughout, incl. DONE
    add(1'b0, W_ADDR_OFS); add_read(0); add(1'b0, W_DONE_REG);
    run(4'b0010, 1'b1, 1'b0);

    // LDI, two wait states per access: 9 cycles to done
    add(1'b0, W_ADDR_OFS); add_read(2); add(1'b0, W_IND); add_read(2); add(1'b0, W_DONE_REG);
    run(4'b1010, 1'b0, 1'b0);

    // STI back-to-back, zero waits
    add(1'b0, W_ADDR_OFS); add_read(0); add(1'b0, W_IND); add(1'b0, W_WRDATA);
    add_write(0); add(1'b0, W_DONE);
    run(4'b1011, 1'b0, 1'b0);

    // TRAP vector fetch
    add(1'b0, W_ADDR_TRAP); add_read(0); add(1'b0, W_DONE);
    run(4'b1111, 1'b0, 1'b0);

    // ST with one write wait state
    add(1'b0, W_ADDR_OFS); add(1'b0, W_WRDATA); add_write(1); add(1'b0, W_DONE);
    run(4'b0011, 1'b0, 1'b0);

    // LDR and STR
    add(1'b0, W_ADDR_OFS); add_read(1); add(1'b0, W_DONE_REG);
    run(4'b0110, 1'b0, 1'b0);
    add(1'b0, W_ADDR_OFS); add(1'b0, W_WRDATA); add_write(0); add(1'b0, W_DONE);
    run(4'b0111, 1'b0, 1'b0);

    // Watchdog: ready never comes, four READ cycles then ERR
    add(1'b0, W_ADDR_OFS);
    for (int i = 0; i < 4; i++) add(1'b0, W_READ);
    add(1'b0, W_ERR);
    run(4'b0010, 1'b0, 1'b0);

    // Write watchdog
    add(1'b0, W_ADDR_OFS); add(1'b0, W_WRDATA);
    for (int i = 0; i < 4; i++) add(1'b0, W_WRITE);
    add(1'b0, W_ERR);
    run(4'b0011, 1'b0, 1'b0);

    // Illegal opcode
    add(1'b0, W_ERR);
    run(4'b0001, 1'b0, 1'b0);

    // Reset in the middle of a WRITE wait
    add(1'b0, W_ADDR_OFS); add(1'b0, W_WRDATA); add(1'b0, W_WRITE);
    run(4'b0011, 1'b0, 1'b1);

    // Normal LD after reset
    add(1'b0, W_ADDR_OFS); add_read(0); add(1'b0, W_DONE_REG);
    run(4'b0010, 1'b0, 1'b0);

    repeat (3) @(posedge i_clk);
    #1;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d expected cycles left required 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
